map_probe_arbiter: RTL
======================

# map_probe_arbiter

Shares one map ROM read port among four movers: pacman and monsters 1–3. Each mover asks whether it may step left, up, right or down from a centre coordinate. The block replaces the per-mover bank of twelve map ROM instances. It arbitrates between the movers, sequences the twelve wall probes through the single ROM port and returns a 4-bit passability vector tagged with the mover's id. It sits between the pacman/monster movement logic and a single mapRom instance in the graphic top level.

## Interface
Parameters:
- ROM_LAT, 0, cycles from rom_x/rom_y valid to rom_pixel valid. Legal values are 0 to 2; 0 means a combinational mapRom.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- req  in  4  level request per mover; index 0 is pacman, indices 1–3 are monsters 1–3
- req_x  in  36  packed centre x coordinates, 9 bits per mover; mover i uses bits [9i+8:9i]
- req_y  in  36  packed centre y coordinates, same packing as req_x
- rom_x  out  9  probe x coordinate to the shared mapRom, in map coordinates
- rom_y  out  9  probe y coordinate to the shared mapRom
- rom_pixel  in  2  mapRom pixel; 2'b00 is wall, any other value is open
- busy  out  1  a query is in service
- done  out  1  one-cycle pulse: the result is valid
- done_id  out  2  id of the mover being answered
- flags  out  4  result vector {D,R,U,L}; a bit is 1 when that direction is passable

## Operation
- FSM has three states: IDLE, PROBE and DONE.
- IDLE → PROBE when any req bit is 1.
  - The arbiter picks the winner and latches the winner's id, x and y.
  - The probe counter is cleared to 0 and the four direction flags are preset to 1.
- In PROBE, the block drives probe k (k = 0 to 11) on rom_x/rom_y.
  - L: 0 (x−13,y), 1 (x−11,y−13), 2 (x−11,y+12).
  - U: 3 (x,y−13), 4 (x−13,y−11), 5 (x+12,y−11).
  - R: 6 (x+12,y), 7 (x+11,y−13), 8 (x+11,y+12).
  - D: 9 (x,y+12), 10 (x−13,y+11), 11 (x+12,y+11).
- Each sampled rom_pixel equal to 00 clears the flag for that probe's direction (probes 0–2 → L, 3–5 → U, 6–8 → R, 9–11 → D).
- A direction is passable only if all three of its probes are open.
- PROBE → DONE once probe 11's pixel has been sampled.
- DONE lasts one cycle and returns to IDLE.
- Arbitration is round-robin. The search starts at the id after the last grant. After reset the last grant is 3, so id 0 is served first.
- Coordinate arithmetic is 9-bit, modulo 512, with no saturation. Out-of-map probes are resolved by mapRom.
- Coordinates are captured at grant. Changing req_x/req_y or dropping req during service does not affect the query, and done still pulses.
- A requester must drop req in the cycle after done if it has no new query. Otherwise it is eligible again.

## Timing
- Let G be an IDLE cycle in which req ≠ 0; the grant is taken at the clock edge that ends G.
- Probe k is driven on rom_x/rom_y during cycle G+1+k. rom_x/rom_y are registered.
- rom_pixel for probe k is sampled at the end of cycle G+1+k+ROM_LAT.
- busy is 1 from cycle G+1 to G+13+ROM_LAT, inclusive.
- done, done_id and flags are valid in cycle G+13+ROM_LAT.
  - flags and done_id hold until the next done.
  - done is 1 for exactly that one cycle.
- The earliest next grant is in cycle G+14+ROM_LAT. One query occupies 14+ROM_LAT cycles (14 at the default).
- Reset values: busy=0, done=0, done_id=0, flags=0, rom_x=0, rom_y=0, FSM=IDLE, last grant=3.
- Reset asserted mid-query aborts the query: no done is issued and all outputs take their reset values immediately.
- If several req bits rise in the same cycle, exactly one is granted. The others wait with no loss.

## Configuration
- `MAP_PROBE_FIXED_PRIO_EN`
  - Defined: arbitration is fixed priority, with id 0 (pacman) highest and id 3 lowest. The last-grant pointer is unused.
  - Undefined: round-robin as described above.

## Test plan
- Open map: ROM model returns 01 everywhere, ROM_LAT=0, req=4'b0001, x=100, y=100. Required: done in cycle G+13, done_id=0, flags=4'b1111, busy high for exactly 13 cycles.
- Probe order: request at (20,30). Required: rom_x/rom_y over cycles G+1 to G+12 are (7,30), (9,17), (9,42), (20,17), (7,19), (32,19), (32,30), (31,17), (31,42), (20,42), (7,41), (32,41).
- Single wall: ROM model returns 00 only at (32,30), ROM_LAT=2, request at (20,30). Required: flags=4'b1011 and done in cycle G+15.
- Wrap: request at (5,5). Required: probe 0 is driven as (504,5) and probe 1 as (506,504).
- Arbitration: req=4'b1111 held permanently from reset.
  - Round-robin build: done_id sequence 0,1,2,3,0, with done pulses 14 cycles apart.
  - With `MAP_PROBE_FIXED_PRIO_EN` defined: done_id is 0 repeatedly.
- Abort: assert reset at G+6, release it, then request id 2. Required: no done for the aborted query, all outputs 0 during reset, and the new query returns done_id=2 after a full 14-cycle sequence.

Source files
------------

// File: rtl/map_probe_arbiter.sv
// map_probe_arbiter
//   Shares one mapRom read port among four movers (pacman = id 0, monsters
//   1-3 = ids 1-3). A granted mover's centre (x,y) is latched. Twelve wall
//   probes (three per direction L,U,R,D) are then issued on rom_x/rom_y.
//   The sampled pixels are folded into a 4-bit passability vector {D,R,U,L}.
//
//   Compile-time option: define MAP_PROBE_FIXED_PRIO_EN to replace the
//   round-robin arbiter with fixed priority (id 0 highest, id 3 lowest).
//
// Parameters
//   ROM_LAT    cycles from rom_x/rom_y to a valid rom_pixel (0..2)
// Ports
//   clk        system clock
//   reset      asynchronous reset, active low
//   req        per-mover level request
//   req_x      packed centre x, 9 bits per mover
//   req_y      packed centre y, 9 bits per mover
//   rom_x      registered probe x to mapRom
//   rom_y      registered probe y to mapRom
//   rom_pixel  mapRom pixel, 2'b00 = wall
//   busy       a query is in service
//   done       one-cycle result strobe
//   done_id    id of the answered mover, held until the next done
//   flags      {D,R,U,L} passability, held until the next done
module map_probe_arbiter #(
    parameter int ROM_LAT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [35:0] req_x,
    input  logic [35:0] req_y,
    output logic [8:0]  rom_x,
    output logic [8:0]  rom_y,
    input  logic [1:0]  rom_pixel,
    output logic        busy,
    output logic        done,
    output logic [1:0]  done_id,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    state_t     state;
    logic [1:0] id_q;
    logic [8:0] x_q;
    logic [8:0] y_q;
    logic [3:0] cnt;      // cycles spent in PROBE; probe cnt is on the bus
    logic [3:0] wflags;   // flags being accumulated for the current query

    logic [1:0] win;
    logic [8:0] win_x;
    logic [8:0] win_y;
    logic       samp;
    logic [3:0] sidx;
    logic       last_samp;
    logic [3:0] clr;

`ifndef MAP_PROBE_FIXED_PRIO_EN
    logic [1:0] last_q;
`endif

    // Probe k relative to the centre, wrapped modulo 512.
    // 9'd499 is -13 and 9'd501 is -11.
    function automatic logic [17:0] probe_xy(input logic [8:0] x,
                                             input logic [8:0] y,
                                             input logic [3:0] k);
        logic [8:0] dx;
        logic [8:0] dy;
        logic [8:0] px;
        logic [8:0] py;
        case (k)
            4'd0:    begin dx = 9'd499; dy = 9'd0;   end
            4'd1:    begin dx = 9'd501; dy = 9'd499; end
            4'd2:    begin dx = 9'd501; dy = 9'd12;  end
            4'd3:    begin dx = 9'd0;   dy = 9'd499; end
            4'd4:    begin dx = 9'd499; dy = 9'd501; end
            4'd5:    begin dx = 9'd12;  dy = 9'd501; end
            4'd6:    begin dx = 9'd12;  dy = 9'd0;   end
            4'd7:    begin dx = 9'd11;  dy = 9'd499; end
            4'd8:    begin dx = 9'd11;  dy = 9'd12;  end
            4'd9:    begin dx = 9'd0;   dy = 9'd12;  end
            4'd10:   begin dx = 9'd499; dy = 9'd11;  end
            default: begin dx = 9'd12;  dy = 9'd11;  end
        endcase
        px = x + dx;
        py = y + dy;
        return {px, py};
    endfunction

    // Direction bit owning probe k: 0-2 L, 3-5 U, 6-8 R, 9-11 D.
    function automatic logic [1:0] dir_of(input logic [3:0] k);
        if (k < 4'd3)      return 2'd0;
        else if (k < 4'd6) return 2'd1;
        else if (k < 4'd9) return 2'd2;
        else               return 2'd3;
    endfunction

    // The first candidate in search order wins, so the loop walks the order
    // backwards and lets later (earlier-in-order) hits overwrite.
    always_comb begin
        win = 2'd0;
`ifdef MAP_PROBE_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) win = 2'(i);
        end
`else
        for (int i = 4; i >= 1; i--) begin
            if (req[last_q + 2'(i)]) win = last_q + 2'(i);
        end
`endif
    end

    assign win_x = req_x[9*int'(win) +: 9];
    assign win_y = req_y[9*int'(win) +: 9];

    // Pixels arrive ROM_LAT cycles behind the probe that produced them.
    generate
        if (ROM_LAT == 0) begin : g_samp0
            assign samp = 1'b1;
        end else begin : g_sampn
            assign samp = (cnt >= 4'(ROM_LAT));
        end
    endgenerate

    assign sidx      = cnt - 4'(ROM_LAT);
    assign last_samp = samp && (sidx == 4'd11);

    always_comb begin
        clr = 4'b0000;
        if (state == PROBE && samp && rom_pixel == 2'b00) clr = 4'b0001 << dir_of(sidx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            id_q    <= 2'd0;
            x_q     <= 9'd0;
            y_q     <= 9'd0;
            cnt     <= 4'd0;
            wflags  <= 4'b0000;
            rom_x   <= 9'd0;
            rom_y   <= 9'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 2'd0;
            flags   <= 4'b0000;
`ifndef MAP_PROBE_FIXED_PRIO_EN
            last_q  <= 2'd3;
`endif
        end else begin
            case (state)
                // Grant: latch the winner and put probe 0 on the bus at once.
                IDLE: begin
                    if (|req) begin
                        state          <= PROBE;
                        id_q           <= win;
                        x_q            <= win_x;
                        y_q            <= win_y;
                        cnt            <= 4'd0;
                        wflags         <= 4'b1111;
                        busy           <= 1'b1;
                        {rom_x, rom_y} <= probe_xy(win_x, win_y, 4'd0);
`ifndef MAP_PROBE_FIXED_PRIO_EN
                        last_q         <= win;
`endif
                    end
                end
                // Issue probes 1..11 and fold in pixels as they return.
                PROBE: begin
                    cnt    <= cnt + 4'd1;
                    wflags <= wflags & ~clr;
                    if (cnt < 4'd11) {rom_x, rom_y} <= probe_xy(x_q, y_q, cnt + 4'd1);
                    if (last_samp) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        done_id <= id_q;
                        flags   <= wflags & ~clr;
                    end
                end
                // Result cycle.
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
